// File: rtl/key_event_pkg.sv
// Shared definitions for the debounced key controller: register map, CTRL bits, key FSM states.
package key_event_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_POL = 1;

  typedef enum logic [1:0] {
    IDLE_HI,
    CHK_LO,
    IDLE_LO,
    CHK_HI
  } key_state_e;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchronizer feeding a tick-driven debounce FSM with a registered level.
module key_debounce_cell
  import key_event_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_i,
  input  logic tick_i,
  output logic level_o
);

  localparam logic [2:0] Target = 3'(STABLE_TICKS);

  logic [1:0] sync_q;
  key_state_e state_q;
  logic [2:0] cnt_q;
  logic       level_q;
  logic       sample;

  assign sample  = sync_q[1];
  assign level_o = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE_HI;
      cnt_q   <= 3'd0;
      level_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], key_i};
      if (tick_i) begin
        unique case (state_q)
          IDLE_HI: begin
            if (!sample) begin
              if (Target == 3'd1) begin
                state_q <= IDLE_LO;
                level_q <= 1'b0;
                cnt_q   <= 3'd0;
              end else begin
                state_q <= CHK_LO;
                cnt_q   <= 3'd1;
              end
            end
          end
          CHK_LO: begin
            if (sample) begin
              state_q <= IDLE_HI;
              cnt_q   <= 3'd0;
            end else if (cnt_q + 3'd1 == Target) begin
              state_q <= IDLE_LO;
              level_q <= 1'b0;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          IDLE_LO: begin
            if (sample) begin
              if (Target == 3'd1) begin
                state_q <= IDLE_HI;
                level_q <= 1'b1;
                cnt_q   <= 3'd0;
              end else begin
                state_q <= CHK_HI;
                cnt_q   <= 3'd1;
              end
            end
          end
          CHK_HI: begin
            if (!sample) begin
              state_q <= IDLE_LO;
              cnt_q   <= 3'd0;
            end else if (cnt_q + 3'd1 == Target) begin
              state_q <= IDLE_HI;
              level_q <= 1'b1;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM key controller: debounced levels, sticky edge capture with W1C, maskable level irq.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STABLE_TICKS    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]  tick_cnt_q, tick_cnt_d;
  logic             tick, en, wr, rd;
  logic [WIDTH-1:0] level, level_prev_q, edge_set;
  logic [WIDTH-1:0] mask_q, mask_d, edgecap_q, edgecap_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic             unused_wdata;

  assign en           = ctrl_q[CTRL_EN];
  assign wr           = chipselect & write;
  assign rd           = chipselect & read;
  assign readdata     = readdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^writedata;

  // Disabled prescaler parks at 0 so the first tick after enable is a full period away.
  always_comb begin
    tick       = en && (tick_cnt_q == CntLast);
    tick_cnt_d = tick_cnt_q;
    if (!en || tick) tick_cnt_d = '0;
    else             tick_cnt_d = tick_cnt_q + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce_cell #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .key_i  (in_port[i]),
      .tick_i (tick),
      .level_o(level[i])
    );
  end

  always_comb begin
    edge_set = ctrl_q[CTRL_POL] ? (~level_prev_q & level) : (level_prev_q & ~level);

    mask_d    = mask_q;
    ctrl_d    = ctrl_q;
    edgecap_d = edgecap_q;
    if (wr) begin
      unique case (address)
        ADDR_MASK:    mask_d    = writedata[WIDTH-1:0];
        ADDR_EDGECAP: edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        ADDR_CTRL:    ctrl_d    = writedata[1:0];
        default:      ;
      endcase
    end
    // A capture in the same cycle as its W1C must not be lost.
    edgecap_d = edgecap_d | edge_set;

    readdata_d = readdata_q;
    if (rd) begin
      readdata_d = '0;
      unique case (address)
        ADDR_DATA:    readdata_d[WIDTH-1:0] = level;
        ADDR_MASK:    readdata_d[WIDTH-1:0] = mask_q;
        ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
        ADDR_CTRL:    readdata_d[1:0]       = ctrl_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q   <= '0;
      level_prev_q <= '1;
      mask_q       <= '0;
      edgecap_q    <= '0;
      ctrl_q       <= 2'b01;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      level_prev_q <= level;
      mask_q       <= mask_d;
      edgecap_q    <= edgecap_d;
      ctrl_q       <= ctrl_d;
      readdata_q   <= readdata_d;
      irq_q        <= |(edgecap_q & mask_q);
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a short prescaler period.
module tb_key_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  key_event_ctrl #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .STABLE_TICKS   (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_vals [4];
    exp_vals[0] = 32'hF; exp_vals[1] = 32'h0; exp_vals[2] = 32'h0; exp_vals[3] = 32'h1;
    reset_n = 1'b0;
    idle_cycles(3);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d);
      checks++;
      if (d !== exp_vals[i]) begin
        failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, d, exp_vals[i]);
      end
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    in_port[0] = 1'b0;
    idle_cycles(20);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hE) begin failures++; $display("FAIL press_data got=%h exp=%h", d, 32'hE); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL press_edgecap got=%h exp=%h", d, 32'h1); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL press_irq_masked got=%b exp=0", irq); end
    in_port[0] = 1'b1;
    idle_cycles(20);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL release_data got=%h exp=%h", d, 32'hF); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL release_nocap got=%h exp=%h", d, 32'h1); end
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL mask_rw got=%h exp=%h", d, 32'h1); end
    in_port[0] = 1'b0;
    idle_cycles(20);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", irq); end
    bus_write(2'd2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold_one got=%b exp=1", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL irq_edgecap got=%h exp=%h", d, 32'h0); end
    in_port[0] = 1'b1;
    idle_cycles(20);
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port[1] = 1'b0;
    idle_cycles(6);
    in_port[1] = 1'b1;
    idle_cycles(20);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL glitch_data got=%h exp=%h", d, 32'hF); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL glitch_edgecap got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_polarity();
    logic [31:0] d;
    bus_write(2'd3, 32'h3);
    in_port[2] = 1'b0;
    idle_cycles(20);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hB) begin failures++; $display("FAIL pol_press_data got=%h exp=%h", d, 32'hB); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL pol_press_nocap got=%h exp=%h", d, 32'h0); end
    in_port[2] = 1'b1;
    idle_cycles(20);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL pol_release_cap got=%h exp=%h", d, 32'h4); end
    bus_write(2'd2, 32'h4);
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bus_write(2'd3, 32'h0);
    in_port[3] = 1'b0;
    idle_cycles(40);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL dis_data got=%h exp=%h", d, 32'hF); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL dis_nocap got=%h exp=%h", d, 32'h0); end
    bus_write(2'd3, 32'h1);
    idle_cycles(20);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h7) begin failures++; $display("FAIL reen_data got=%h exp=%h", d, 32'h7); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL reen_cap got=%h exp=%h", d, 32'h8); end
    in_port[3] = 1'b1;
    idle_cycles(20);
    bus_write(2'd2, 32'h8);
  endtask

  // W1C of bit3 held every cycle while key3 is pressed: the capture must still show up.
  task automatic test_set_vs_clear();
    bit saw_rd  = 1'b0;
    bit saw_irq = 1'b0;
    logic [31:0] d;
    bus_write(2'd1, 32'h8);
    @(negedge clk);
    address = 2'd2; writedata = 32'h8; chipselect = 1'b1; write = 1'b1; read = 1'b1;
    in_port[3] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (readdata === 32'h8) saw_rd = 1'b1;
      if (irq === 1'b1) saw_irq = 1'b1;
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    checks++;
    if (saw_rd !== 1'b1) begin failures++; $display("FAIL setwins_read got=%b exp=1", saw_rd); end
    checks++;
    if (saw_irq !== 1'b1) begin failures++; $display("FAIL setwins_irq got=%b exp=1", saw_irq); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL setwins_after got=%h exp=%h", d, 32'h0); end
  endtask

  initial begin
    reset_n = 1'b1; in_port = 4'hF; address = '0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; writedata = '0;
    test_reset();
    test_press();
    test_irq();
    test_glitch();
    test_polarity();
    test_disable();
    test_set_vs_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
